// File: rtl/hub75_bitplane_scan_if.sv
// Frame-buffer read port and HUB75 panel drive signals of the bit-plane scanner.
// The scanner owns the master side; the RAM/panel side (or a bench) owns the slave side.
interface hub75_bitplane_scan_if;
   logic [10:0] ram_rd_addr;    // {half, row[3:0], col[5:0]}
   logic [15:0] ram_rd_data;    // RGB565, valid one cycle after ram_rd_addr
   logic [2:0]  rgb1;           // top-half bits {b,g,r}
   logic [2:0]  rgb2;           // bottom-half bits {b,g,r}
   logic        pixclock;
   logic        latch;
   logic        output_enable;  // active-low
   logic [3:0]  row_address;
   logic        frame_done;

   modport master (
      output ram_rd_addr,
      input  ram_rd_data,
      output rgb1,
      output rgb2,
      output pixclock,
      output latch,
      output output_enable,
      output row_address,
      output frame_done
   );

   modport slave (
      input  ram_rd_addr,
      output ram_rd_data,
      input  rgb1,
      input  rgb2,
      input  pixclock,
      input  latch,
      input  output_enable,
      input  row_address,
      input  frame_done
   );
endinterface

// File: rtl/hub75_bitplane_scan.sv
// HUB75 64x32 scanner: 16 row pairs, 6-plane binary-coded modulation.
// Each plane: 64 columns x 4-cycle shift, one blank cycle, one latch cycle,
// then a display window of BASE_TICKS<<plane cycles.
module hub75_bitplane_scan #(
   parameter int BASE_TICKS        = 2,
   parameter int DISPLAY_CNT_WIDTH = 8
) (
   input  logic                  clk_in,
   input  logic                  reset,
   input  logic [2:0]            rgb_enable,
   input  logic [5:0]            brightness_enable,
   hub75_bitplane_scan_if.master bus
);

   // SHIFT is split into its four column phases so the phase is part of the state.
   typedef enum logic [2:0] {
      S_P0,       // address top-half pixel
      S_P1,       // capture top pixel, address bottom-half pixel
      S_P2,       // drive rgb bits, pixclock low
      S_P3,       // pixclock high, advance column
      S_BLANK,
      S_LATCH,
      S_DISPLAY
   } state_e;

   state_e                       state_q, state_d;
   logic [5:0]                   col_q, col_d;
   logic [3:0]                   row_q, row_d;
   logic [2:0]                   plane_q, plane_d;
   logic [DISPLAY_CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                         en_q, en_d;
   logic [15:0]                  top_q, top_d;
   logic [2:0]                   rgb1_q, rgb1_d;
   logic [2:0]                   rgb2_q, rgb2_d;
   logic [3:0]                   row_address_q, row_address_d;
   logic                         last_tick;

   // Expand RGB565 to three 6-bit channels and pick the current plane's bit.
   function automatic logic [2:0] plane_bits(input logic [15:0] px,
                                             input logic [2:0]  pl,
                                             input logic [2:0]  mask);
      logic [5:0] r6, g6, b6;
      r6 = {px[15:11], px[15]};
      g6 = px[10:5];
      b6 = {px[4:0], px[4]};
      return {b6[pl], g6[pl], r6[pl]} & mask;
   endfunction

   assign last_tick = (state_q == S_DISPLAY) &&
                      (cnt_q == DISPLAY_CNT_WIDTH'(1));

   // State and datapath registers with synchronous active-high reset.
   always_ff @(posedge clk_in) begin
      // NOTE: non-blocking assignments here so every flop samples pre-edge values.
      if (reset) begin
         state_q       <= S_P0;
         col_q         <= '0;
         row_q         <= '0;
         plane_q       <= '0;
         cnt_q         <= '0;
         en_q          <= 1'b0;
         top_q         <= '0;
         rgb1_q        <= '0;
         rgb2_q        <= '0;
         row_address_q <= '0;
      end else begin
         state_q       <= state_d;
         col_q         <= col_d;
         row_q         <= row_d;
         plane_q       <= plane_d;
         cnt_q         <= cnt_d;
         en_q          <= en_d;
         top_q         <= top_d;
         rgb1_q        <= rgb1_d;
         rgb2_q        <= rgb2_d;
         row_address_q <= row_address_d;
      end
   end

   // Next-state sequencing through shift, blank, latch and display.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_P0:      state_d = S_P1;
         S_P1:      state_d = S_P2;
         S_P2:      state_d = S_P3;
         S_P3:      state_d = (col_q == 6'd63) ? S_BLANK : S_P0;
         S_BLANK:   state_d = S_LATCH;
         S_LATCH:   state_d = S_DISPLAY;
         S_DISPLAY: state_d = last_tick ? S_P0 : S_DISPLAY;
         default:   state_d = S_P0;
      endcase
   end

   // Datapath: pixel capture, column/plane/row counters, display timer.
   always_comb begin
      // NOTE: every target gets a hold default first so no latch is inferred.
      col_d         = col_q;
      row_d         = row_q;
      plane_d       = plane_q;
      cnt_d         = cnt_q;
      en_d          = en_q;
      top_d         = top_q;
      rgb1_d        = rgb1_q;
      rgb2_d        = rgb2_q;
      row_address_d = row_address_q;
      unique case (state_q)
         S_P1: top_d = bus.ram_rd_data;
         S_P2: begin
            rgb1_d = plane_bits(top_q, plane_q, rgb_enable);
            rgb2_d = plane_bits(bus.ram_rd_data, plane_q, rgb_enable);
         end
         S_P3: col_d = col_q + 6'd1;
         S_LATCH: begin
            row_address_d = row_q;
            en_d          = brightness_enable[plane_q];
            cnt_d         = DISPLAY_CNT_WIDTH'(BASE_TICKS << plane_q);
         end
         S_DISPLAY: begin
            cnt_d = cnt_q - DISPLAY_CNT_WIDTH'(1);
            if (last_tick) begin
               if (plane_q == 3'd5) begin
                  plane_d = 3'd0;
                  row_d   = row_q + 4'd1;
               end else begin
                  plane_d = plane_q + 3'd1;
               end
            end
         end
         default: ;
      endcase
   end

   // Panel and RAM outputs decoded from the current state.
   always_comb begin
      bus.ram_rd_addr   = {(state_q == S_P1), row_q, col_q};
      // New bits appear during p2 and are held by rgb*_q from p3 onwards.
      bus.rgb1          = rgb1_d;
      bus.rgb2          = rgb2_d;
      bus.pixclock      = (state_q == S_P3);
      bus.latch         = (state_q == S_LATCH);
      bus.output_enable = ~((state_q == S_DISPLAY) && en_q);
      bus.row_address   = row_address_q;
      bus.frame_done    = last_tick && (plane_q == 3'd5) && (row_q == 4'd15);
   end

endmodule

// File: tb/tb_hub75_bitplane_scan.sv
// Bench for hub75_bitplane_scan: column vector table, hand sequences for
// brightness gating / frame wrap / mid-run reset, and a randomized run
// compared every cycle against a cycle-index reference model.
module tb_hub75_bitplane_scan;
   localparam int BASE     = 2;
   localparam int ROW_CYC  = 6 * 258 + BASE * 63;   // 1674
   localparam int FRAME    = 16 * ROW_CYC;          // 26784

   logic       clk_in = 1'b0;
   logic       reset;
   logic [2:0] rgb_enable;
   logic [5:0] brightness_enable;

   hub75_bitplane_scan_if bus ();

   hub75_bitplane_scan #(.BASE_TICKS(BASE), .DISPLAY_CNT_WIDTH(8)) dut (
      .clk_in            (clk_in),
      .reset             (reset),
      .rgb_enable        (rgb_enable),
      .brightness_enable (brightness_enable),
      .bus               (bus)
   );

   always #5 clk_in = ~clk_in;

   // Frame buffer with one cycle of read latency.
   logic [15:0] mem [2048];
   always @(posedge clk_in) bus.ram_rd_data <= mem[bus.ram_rd_addr];

   int checks = 0;
   int errors = 0;
   int t = 0;          // cycle index within the frame since reset release

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0d)", name, act, exp, t);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      int row;
      int plane;
      int off;
      int dlen;
   } pos_t;

   // Locate a frame cycle: row pair, plane, offset inside that plane's slot.
   function automatic pos_t where(input int tt);
      pos_t p;
      int   o;
      p.row   = tt / ROW_CYC;
      o       = tt % ROW_CYC;
      p.plane = 0;
      while (o >= 258 + (BASE << p.plane)) begin
         o -= 258 + (BASE << p.plane);
         p.plane++;
      end
      p.off  = o;
      p.dlen = BASE << p.plane;
      return p;
   endfunction

   function automatic logic [2:0] spec_bits(input logic [15:0] px, input int plane,
                                            input logic [2:0] mask);
      logic [5:0] r6, g6, b6;
      r6 = {px[15:11], px[15]};
      g6 = px[10:5];
      b6 = {px[4:0], px[4]};
      return {b6[plane], g6[plane], r6[plane]} & mask;
   endfunction

   function automatic logic [10:0] addr_of(input int half, input int row, input int col);
      return 11'(half * 1024 + row * 64 + col);
   endfunction

   logic       m_en;
   logic [3:0] m_row_addr;
   logic [2:0] m_rgb1, m_rgb2;
   bit         chk_on = 1'b0;

   always @(posedge clk_in) begin : model_step
      pos_t p;
      if (reset) begin
         t          <= 0;
         m_en       <= 1'b0;
         m_row_addr <= '0;
         m_rgb1     <= '0;
         m_rgb2     <= '0;
      end else begin
         p = where(t);
         if (p.off == 257) begin
            m_en       <= brightness_enable[p.plane];
            m_row_addr <= 4'(p.row);
         end
         if (p.off < 256 && p.off % 4 == 2) begin
            m_rgb1 <= spec_bits(mem[addr_of(0, p.row, p.off / 4)], p.plane, rgb_enable);
            m_rgb2 <= spec_bits(mem[addr_of(1, p.row, p.off / 4)], p.plane, rgb_enable);
         end
         t <= (t + 1) % FRAME;
      end
   end

   always @(negedge clk_in) begin : model_check
      pos_t       p;
      bit         shift;
      int         col, ph;
      logic [2:0] e1, e2;
      if (chk_on) begin
         p     = where(t);
         shift = (p.off < 256);
         col   = p.off / 4;
         ph    = p.off % 4;
         if (shift && ph < 2)
            check("m_addr", 32'(bus.ram_rd_addr), 32'(addr_of(ph, p.row, col)));
         check("m_pixclock", 32'(bus.pixclock), 32'(shift && ph == 3));
         check("m_latch", 32'(bus.latch), 32'(p.off == 257));
         check("m_oe", 32'(bus.output_enable), 32'(!(p.off >= 258 && m_en)));
         check("m_row_address", 32'(bus.row_address), 32'(m_row_addr));
         check("m_frame_done", 32'(bus.frame_done),
               32'(p.row == 15 && p.plane == 5 && p.off == 258 + p.dlen - 1));
         if (shift && ph == 2) begin
            e1 = spec_bits(mem[addr_of(0, p.row, col)], p.plane, rgb_enable);
            e2 = spec_bits(mem[addr_of(1, p.row, col)], p.plane, rgb_enable);
         end else begin
            e1 = m_rgb1;
            e2 = m_rgb2;
         end
         check("m_rgb1", 32'(bus.rgb1), 32'(e1));
         check("m_rgb2", 32'(bus.rgb2), 32'(e2));
      end
   end

   // Wait (at negedges) until the frame cycle index reaches n; bounded.
   task automatic goto_cycle(input int n);
      int guard;
      guard = 0;
      while (t != n && guard < FRAME + 10) begin
         @(negedge clk_in);
         guard++;
      end
      check("goto_timeout", 32'(t), 32'(n));
   endtask

   // ---------------- column vector table (plane 0, row 0) ----------------
   typedef struct {
      logic [15:0] top;
      logic [15:0] bot;
      logic [2:0]  en;
      logic [2:0]  exp1;
      logic [2:0]  exp2;
   } vec_t;

   vec_t vecs [8];
   int   ps [7];
   int   oe_low [6];
   int   first_low [6];
   int   fd_cnt, fd_at, latch_cnt;
   logic [3:0] last_ra;
   logic [3:0] ra_seq [$];

   initial begin
      vecs[0] = '{16'hFFFF, 16'h0000, 3'b111, 3'b111, 3'b000};
      vecs[1] = '{16'h8000, 16'h0020, 3'b111, 3'b001, 3'b010};
      vecs[2] = '{16'h0010, 16'h7BEF, 3'b111, 3'b100, 3'b010};
      vecs[3] = '{16'hFFFF, 16'hFFFF, 3'b010, 3'b010, 3'b010};
      vecs[4] = '{16'hFFFF, 16'hFFFF, 3'b000, 3'b000, 3'b000};
      vecs[5] = '{16'h4000, 16'h0800, 3'b111, 3'b000, 3'b000};
      vecs[6] = '{16'hF81F, 16'h07E0, 3'b101, 3'b101, 3'b000};
      vecs[7] = '{16'h0020, 16'h8010, 3'b110, 3'b010, 3'b100};

      ps[0] = 0;
      for (int p = 0; p < 6; p++) ps[p + 1] = ps[p] + 258 + (BASE << p);

      // ---- reset state ----
      reset             = 1'b1;
      rgb_enable        = 3'b111;
      brightness_enable = 6'h3F;
      for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;
      for (int c = 0; c < 8; c++) begin
         mem[addr_of(0, 0, c)] = vecs[c].top;
         mem[addr_of(1, 0, c)] = vecs[c].bot;
      end
      @(posedge clk_in); #1 chk_on = 1'b1;
      @(posedge clk_in);
      @(negedge clk_in);
      check("rst_oe", 32'(bus.output_enable), 32'(1));
      check("rst_latch", 32'(bus.latch), 32'(0));
      check("rst_pixclock", 32'(bus.pixclock), 32'(0));
      check("rst_row_address", 32'(bus.row_address), 32'(0));
      check("rst_addr", 32'(bus.ram_rd_addr), 32'(0));
      check("rst_frame_done", 32'(bus.frame_done), 32'(0));
      check("rst_rgb1", 32'(bus.rgb1), 32'(0));
      @(posedge clk_in); #1 reset = 1'b0;
      @(negedge clk_in);
      check("first_addr", 32'(bus.ram_rd_addr), 32'h000);
      @(negedge clk_in);
      check("second_addr", 32'(bus.ram_rd_addr), 32'h400);

      // ---- column table: rgb at p2, pixclock one cycle later ----
      for (int c = 0; c < 8; c++) begin
         goto_cycle(4 * c + 1);
         @(posedge clk_in); #1 rgb_enable = vecs[c].en;
         @(negedge clk_in);
         check($sformatf("col%0d_rgb1", c), 32'(bus.rgb1), 32'(vecs[c].exp1));
         check($sformatf("col%0d_rgb2", c), 32'(bus.rgb2), 32'(vecs[c].exp2));
         check($sformatf("col%0d_pixclock_p2", c), 32'(bus.pixclock), 32'(0));
         @(negedge clk_in);
         check($sformatf("col%0d_pixclock_p3", c), 32'(bus.pixclock), 32'(1));
         check($sformatf("col%0d_rgb1_held", c), 32'(bus.rgb1), 32'(vecs[c].exp1));
      end

      // ---- channel mask, brightness gating, frame wrap ----
      @(posedge clk_in); #1;
      reset             = 1'b1;
      rgb_enable        = 3'b010;
      brightness_enable = 6'b000001;
      for (int i = 0; i < 2048; i++) mem[i] = 16'hFFFF;
      @(posedge clk_in); #1;
      @(posedge clk_in); #1 reset = 1'b0;
      for (int p = 0; p < 6; p++) begin
         oe_low[p]    = 0;
         first_low[p] = -1;
      end
      fd_cnt = 0;
      fd_at  = -1;
      ra_seq.delete();
      for (int n = 0; n < FRAME + 300; n++) begin
         @(negedge clk_in);
         if (n == 0) begin
            last_ra = bus.row_address;
            ra_seq.push_back(last_ra);
         end else if (bus.row_address !== last_ra) begin
            last_ra = bus.row_address;
            ra_seq.push_back(last_ra);
         end
         if (n < ROW_CYC) begin
            for (int p = 0; p < 6; p++) begin
               if (n == ps[p] + 2) begin
                  check($sformatf("mask_plane%0d_rgb1", p), 32'(bus.rgb1), 32'(3'b010));
                  check($sformatf("mask_plane%0d_rgb2", p), 32'(bus.rgb2), 32'(3'b010));
               end
               if (n >= ps[p] && n < ps[p + 1] && bus.output_enable == 1'b0) begin
                  oe_low[p]++;
                  if (first_low[p] < 0) first_low[p] = n;
               end
            end
         end
         if (bus.frame_done === 1'b1) begin
            fd_cnt++;
            fd_at = n;
         end
      end
      check("oe_plane0_cycles", 32'(oe_low[0]), 32'(BASE));
      check("oe_plane0_start", 32'(first_low[0]), 32'(ps[0] + 258));
      for (int p = 1; p < 6; p++)
         check($sformatf("oe_plane%0d_cycles", p), 32'(oe_low[p]), 32'(0));
      check("frame_done_count", 32'(fd_cnt), 32'(1));
      check("frame_done_cycle", 32'(fd_at), 32'(FRAME - 1));
      check("row_seq_len", 32'(ra_seq.size()), 32'(17));
      for (int i = 0; i < ra_seq.size() && i < 17; i++)
         check($sformatf("row_seq_%0d", i), 32'(ra_seq[i]), 32'(i % 16));

      // ---- randomized run against the model ----
      @(posedge clk_in); #1;
      reset = 1'b1;
      for (int i = 0; i < 2048; i++) mem[i] = 16'($urandom);
      rgb_enable        = 3'($urandom);
      brightness_enable = 6'($urandom);
      @(posedge clk_in); #1;
      @(posedge clk_in); #1 reset = 1'b0;
      for (int n = 0; n < FRAME + 500; n++) begin
         @(posedge clk_in); #1;
         if ($urandom_range(0, 150) == 0) rgb_enable = 3'($urandom);
         if ($urandom_range(0, 300) == 0) brightness_enable = 6'($urandom);
      end

      // ---- reset in the middle of row 3, column 20 ----
      @(negedge clk_in);
      goto_cycle(3 * ROW_CYC + 20 * 4);
      reset     = 1'b1;
      latch_cnt = 0;
      @(negedge clk_in);
      check("midrst_addr", 32'(bus.ram_rd_addr), 32'(0));
      check("midrst_oe", 32'(bus.output_enable), 32'(1));
      check("midrst_latch", 32'(bus.latch), 32'(0));
      check("midrst_pixclock", 32'(bus.pixclock), 32'(0));
      check("midrst_row_address", 32'(bus.row_address), 32'(0));
      check("midrst_frame_done", 32'(bus.frame_done), 32'(0));
      @(posedge clk_in); #1 reset = 1'b0;
      for (int n = 0; n < 257; n++) begin
         @(negedge clk_in);
         if (n == 0) check("midrst_first_addr", 32'(bus.ram_rd_addr), 32'h000);
         if (n == 1) check("midrst_second_addr", 32'(bus.ram_rd_addr), 32'h400);
         if (bus.latch !== 1'b0) latch_cnt++;
      end
      check("midrst_no_latch", 32'(latch_cnt), 32'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
